otter_mc_ctrl: RTL and testbench

OTTER_MC_CTRL -- requirements
Module: otter_mc_ctrl

---
 rtl/otter_pkg.sv | 58 +++++
 rtl/otter_branch_cond.sv | 31 +++
 rtl/otter_mc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_otter_mc_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// -----------------------------------------------------------------------------
// otter_pkg
// Shared definitions for the OTTER multicycle control unit: the FSM state
// type, RV32I major opcodes, and the select encodings for the PC, ALU-B and
// register-file writeback muxes.
// -----------------------------------------------------------------------------
package otter_pkg;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_MEM    = 2'd3
   } state_t;

   // RV32I major opcodes (IR[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // PC mux selects; 4 and 5 are held back for trap entry / return
   localparam logic [3:0] PCSRC_NEXT   = 4'd0;
   localparam logic [3:0] PCSRC_JALR   = 4'd1;
   localparam logic [3:0] PCSRC_BRANCH = 4'd2;
   localparam logic [3:0] PCSRC_JAL    = 4'd3;
   localparam logic [3:0] PCSRC_MTVEC  = 4'd4;
   localparam logic [3:0] PCSRC_MEPC   = 4'd5;

   // ALU-A mux selects
   localparam logic       SRCA_RS1  = 1'b0;
   localparam logic       SRCA_UIMM = 1'b1;

   // ALU-B mux selects
   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IIMM = 2'd1;
   localparam logic [1:0] SRCB_SIMM = 2'd2;
   localparam logic [1:0] SRCB_PC   = 2'd3;

   // Register-file writeback mux selects
   localparam logic [1:0] WSEL_PC4 = 2'd0;
   localparam logic [1:0] WSEL_CSR = 2'd1;
   localparam logic [1:0] WSEL_MEM = 2'd2;
   localparam logic [1:0] WSEL_ALU = 2'd3;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_LUI = 4'b1001;

   function automatic logic is_mem_op(input logic [6:0] opc);
      return (opc == OPC_LOAD) || (opc == OPC_STORE);
   endfunction

endpackage

// File: rtl/otter_branch_cond.sv
// -----------------------------------------------------------------------------
// otter_branch_cond
// Decides whether a conditional branch is taken from FUNC3 and the three
// comparator flags.
//   FUNC3  in  3  branch kind (IR[14:12])
//   BR_EQ  in  1  rs1 == rs2
//   BR_LT  in  1  signed rs1 < rs2
//   BR_LTU in  1  unsigned rs1 < rs2
//   TAKEN  out 1  branch taken
// -----------------------------------------------------------------------------
module otter_branch_cond (
   input  logic [2:0] FUNC3,
   input  logic       BR_EQ,
   input  logic       BR_LT,
   input  logic       BR_LTU,
   output logic       TAKEN
);

   // FUNC3[2:1] picks the comparison, FUNC3[0] inverts it.
   // 010/011 are not branch encodings and never branch.
   always_comb begin
      TAKEN = 1'b0;
      case (FUNC3[2:1])
         2'b00:   TAKEN = BR_EQ  ^ FUNC3[0];
         2'b10:   TAKEN = BR_LT  ^ FUNC3[0];
         2'b11:   TAKEN = BR_LTU ^ FUNC3[0];
         default: TAKEN = 1'b0;
      endcase
   end

endmodule

// File: rtl/otter_mc_ctrl.sv
// -----------------------------------------------------------------------------
// otter_mc_ctrl
// Multicycle control FSM for the OTTER RV32I core (INIT/FETCH/DECODE/MEM).
// Outputs are combinational from the state and the current inputs; only the
// state register is sequential.
//   CLK, RST               clock, asynchronous active-low reset
//   OPCODE/FUNC3/FUNC7_5   instruction fields from IR
//   BR_EQ/BR_LT/BR_LTU     comparator flags
//   MEM_READY              cache access complete this cycle
//   PC_WRITE/IR_WRITE/REG_WRITE  register write enables
//   MEM_RDEN1              instruction fetch request
//   MEM_RDEN2/MEM_WE2      data read / write request
//   PC_SOURCE/ALU_SRCA/ALU_SRCB/RF_WR_SEL/ALU_FUN  datapath selects
// -----------------------------------------------------------------------------
module otter_mc_ctrl
   import otter_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] OPCODE,
   input  logic [2:0] FUNC3,
   input  logic       FUNC7_5,
   input  logic       BR_EQ,
   input  logic       BR_LT,
   input  logic       BR_LTU,
   input  logic       MEM_READY,
   output logic       PC_WRITE,
   output logic       IR_WRITE,
   output logic       REG_WRITE,
   output logic       MEM_RDEN1,
   output logic       MEM_RDEN2,
   output logic       MEM_WE2,
   output logic [3:0] PC_SOURCE,
   output logic       ALU_SRCA,
   output logic [1:0] ALU_SRCB,
   output logic [1:0] RF_WR_SEL,
   output logic [3:0] ALU_FUN
);

   state_t state_q, state_d;
   logic   br_taken;

   otter_branch_cond u_branch_cond (
      .FUNC3  (FUNC3),
      .BR_EQ  (BR_EQ),
      .BR_LT  (BR_LT),
      .BR_LTU (BR_LTU),
      .TAKEN  (br_taken)
   );

   // Reset lands in INIT, whose outputs are all zero, so every enable drops
   // the moment RST goes low.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= ST_INIT;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      PC_WRITE  = 1'b0;
      IR_WRITE  = 1'b0;
      REG_WRITE = 1'b0;
      MEM_RDEN1 = 1'b0;
      MEM_RDEN2 = 1'b0;
      MEM_WE2   = 1'b0;
      PC_SOURCE = PCSRC_NEXT;
      ALU_SRCA  = SRCA_RS1;
      ALU_SRCB  = SRCB_RS2;
      RF_WR_SEL = WSEL_PC4;
      ALU_FUN   = ALU_ADD;

      case (state_q)
         ST_INIT: state_d = ST_FETCH;

         ST_FETCH: begin
            MEM_RDEN1 = 1'b1;
            if (MEM_READY) begin
               IR_WRITE = 1'b1;
               state_d  = ST_DECODE;
            end
         end

         // MEM_READY is deliberately not looked at here.
         ST_DECODE: begin
            state_d = is_mem_op(OPCODE) ? ST_MEM : ST_FETCH;
            case (OPCODE)
               OPC_OP: begin
                  REG_WRITE = 1'b1;
                  RF_WR_SEL = WSEL_ALU;
                  PC_WRITE  = 1'b1;
                  ALU_FUN   = {FUNC7_5, FUNC3};
               end
               OPC_OPIMM: begin
                  REG_WRITE = 1'b1;
                  RF_WR_SEL = WSEL_ALU;
                  PC_WRITE  = 1'b1;
                  ALU_SRCB  = SRCB_IIMM;
                  // FUNC7_5 only distinguishes SRLI/SRAI among immediates
                  ALU_FUN   = (FUNC3 == 3'b101) ? {FUNC7_5, FUNC3} : {1'b0, FUNC3};
               end
               OPC_LUI: begin
                  REG_WRITE = 1'b1;
                  RF_WR_SEL = WSEL_ALU;
                  PC_WRITE  = 1'b1;
                  ALU_SRCA  = SRCA_UIMM;
                  ALU_FUN   = ALU_LUI;
               end
               OPC_AUIPC: begin
                  REG_WRITE = 1'b1;
                  RF_WR_SEL = WSEL_ALU;
                  PC_WRITE  = 1'b1;
                  ALU_SRCA  = SRCA_UIMM;
                  ALU_SRCB  = SRCB_PC;
               end
               OPC_JAL: begin
                  REG_WRITE = 1'b1;
                  RF_WR_SEL = WSEL_PC4;
                  PC_WRITE  = 1'b1;
                  PC_SOURCE = PCSRC_JAL;
               end
               OPC_JALR: begin
                  REG_WRITE = 1'b1;
                  RF_WR_SEL = WSEL_PC4;
                  PC_WRITE  = 1'b1;
                  PC_SOURCE = PCSRC_JALR;
                  ALU_SRCB  = SRCB_IIMM;
               end
               OPC_BRANCH: begin
                  PC_WRITE  = 1'b1;
                  PC_SOURCE = br_taken ? PCSRC_BRANCH : PCSRC_NEXT;
               end
               OPC_LOAD: begin
                  MEM_RDEN2 = 1'b1;
                  ALU_SRCB  = SRCB_IIMM;
               end
               OPC_STORE: begin
                  MEM_WE2  = 1'b1;
                  ALU_SRCB = SRCB_SIMM;
               end
               default: PC_WRITE = 1'b1;
            endcase
         end

         // IR still holds the load/store, so OPCODE picks which request to hold.
         ST_MEM: begin
            if (OPCODE == OPC_LOAD) begin
               MEM_RDEN2 = 1'b1;
               ALU_SRCB  = SRCB_IIMM;
            end else begin
               MEM_WE2  = 1'b1;
               ALU_SRCB = SRCB_SIMM;
            end
            if (MEM_READY) begin
               PC_WRITE = 1'b1;
               state_d  = ST_FETCH;
               if (OPCODE == OPC_LOAD) begin
                  REG_WRITE = 1'b1;
                  RF_WR_SEL = WSEL_MEM;
               end
            end
         end

         default: state_d = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_otter_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otter_mc_ctrl
// Scoreboard bench: the driver turns each instruction into its per-cycle
// input values and expected control word, queued in order; the monitor pops
// one entry per cycle on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_otter_mc_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [6:0] OPCODE = '0;
   logic [2:0] FUNC3 = '0;
   logic       FUNC7_5 = 1'b0;
   logic       BR_EQ = 1'b0, BR_LT = 1'b0, BR_LTU = 1'b0;
   logic       MEM_READY = 1'b0;
   logic       PC_WRITE, IR_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2;
   logic [3:0] PC_SOURCE;
   logic       ALU_SRCA;
   logic [1:0] ALU_SRCB;
   logic [1:0] RF_WR_SEL;
   logic [3:0] ALU_FUN;

   otter_mc_ctrl dut (
      .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .FUNC3(FUNC3), .FUNC7_5(FUNC7_5),
      .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU), .MEM_READY(MEM_READY),
      .PC_WRITE(PC_WRITE), .IR_WRITE(IR_WRITE), .REG_WRITE(REG_WRITE),
      .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
      .PC_SOURCE(PC_SOURCE), .ALU_SRCA(ALU_SRCA), .ALU_SRCB(ALU_SRCB),
      .RF_WR_SEL(RF_WR_SEL), .ALU_FUN(ALU_FUN)
   );

   always #5 CLK = ~CLK;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;

   logic [18:0] exp_q[$];
   string       tag_q[$];
   int          n_checks = 0;
   int          n_pass = 0;

   // control word: pcw irw rw rd1 rd2 we2 pcs[4] sa sb[2] ws[2] fn[4]
   function automatic logic [18:0] mk(bit pcw, bit irw, bit rw, bit rd1, bit rd2, bit we2,
                                      logic [3:0] pcs, bit sa, logic [1:0] sb,
                                      logic [1:0] ws, logic [3:0] fn);
      return {pcw, irw, rw, rd1, rd2, we2, pcs, sa, sb, ws, fn};
   endfunction

   wire [18:0] act = {PC_WRITE, IR_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
                      PC_SOURCE, ALU_SRCA, ALU_SRCB, RF_WR_SEL, ALU_FUN};

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         logic [18:0] e;
         string       t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_checks++;
         if (act === e) n_pass++;
         else $display("FAIL %s at %0t: got %b required %b", t, $time, act, e);
      end
   end

   // Reference: branch outcome straight from the RV32I branch table.
   function automatic bit ref_taken(logic [2:0] f3, bit eq, bit lt, bit ltu);
      case (f3)
         3'b000: return eq;
         3'b001: return !eq;
         3'b100: return lt;
         3'b101: return !lt;
         3'b110: return ltu;
         3'b111: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit is_known(logic [6:0] o);
      return o == LUI || o == AUIPC || o == JAL || o == JALR || o == BRANCH ||
             o == LOAD || o == STORE || o == OPIMM || o == OP;
   endfunction

   // Reference: what the decode cycle of one instruction must drive.
   function automatic logic [18:0] ref_decode(logic [6:0] o, logic [2:0] f3, bit f7,
                                              bit eq, bit lt, bit ltu);
      if (o == OP)     return mk(1,0,1,0,0,0, 4'd0, 0, 2'd0, 2'd3, {f7, f3});
      if (o == OPIMM)  return mk(1,0,1,0,0,0, 4'd0, 0, 2'd1, 2'd3,
                                 (f3 == 3'b101) ? {f7, f3} : {1'b0, f3});
      if (o == LUI)    return mk(1,0,1,0,0,0, 4'd0, 1, 2'd0, 2'd3, 4'b1001);
      if (o == AUIPC)  return mk(1,0,1,0,0,0, 4'd0, 1, 2'd3, 2'd3, 4'b0000);
      if (o == JAL)    return mk(1,0,1,0,0,0, 4'd3, 0, 2'd0, 2'd0, 4'b0000);
      if (o == JALR)   return mk(1,0,1,0,0,0, 4'd1, 0, 2'd1, 2'd0, 4'b0000);
      if (o == BRANCH) return mk(1,0,0,0,0,0, ref_taken(f3, eq, lt, ltu) ? 4'd2 : 4'd0,
                                 0, 2'd0, 2'd0, 4'b0000);
      if (o == LOAD)   return mk(0,0,0,0,1,0, 4'd0, 0, 2'd1, 2'd0, 4'b0000);
      if (o == STORE)  return mk(0,0,0,0,0,1, 4'd0, 0, 2'd2, 2'd0, 4'b0000);
      return mk(1,0,0,0,0,0, 4'd0, 0, 2'd0, 2'd0, 4'b0000);
   endfunction

   function automatic logic [18:0] ref_mem(logic [6:0] o, bit rdy);
      bit ld;
      ld = (o == LOAD);
      return mk(rdy, 0, rdy && ld, 0, ld, !ld, 4'd0, 0, ld ? 2'd1 : 2'd2,
                (rdy && ld) ? 2'd2 : 2'd0, 4'b0000);
   endfunction

   task automatic step(bit rst, logic [6:0] o, logic [2:0] f3, bit f7, bit eq, bit lt,
                       bit ltu, bit rdy, logic [18:0] e, string tag);
      @(posedge CLK);
      #1;
      RST = rst; OPCODE = o; FUNC3 = f3; FUNC7_5 = f7;
      BR_EQ = eq; BR_LT = lt; BR_LTU = ltu; MEM_READY = rdy;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic step_rand(bit rst, bit rdy, logic [18:0] e, string tag);
      step(rst, 7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), rdy, e, tag);
   endtask

   // Reset for n cycles with random inputs, then one INIT cycle after release.
   task automatic reset_seq(int n);
      for (int i = 0; i < n; i++) step_rand(0, 1'($urandom), '0, "reset_outputs");
      step_rand(1, 1'($urandom), '0, "init_outputs");
   endtask

   task automatic instr(logic [6:0] o, logic [2:0] f3, bit f7, bit eq, bit lt, bit ltu,
                        int fstall, int mstall, int rst_at);
      for (int i = 0; i < fstall; i++)
         step_rand(1, 0, mk(0,0,0,1,0,0, 4'd0, 0, 2'd0, 2'd0, 4'd0), "fetch_stall");
      step_rand(1, 1, mk(0,1,0,1,0,0, 4'd0, 0, 2'd0, 2'd0, 4'd0), "fetch_ready");
      step(1, o, f3, f7, eq, lt, ltu, 1'($urandom), ref_decode(o, f3, f7, eq, lt, ltu),
           "decode");
      if (o == LOAD || o == STORE) begin
         for (int i = 0; i < mstall; i++) begin
            if (i == rst_at) begin
               // RST drops mid-stall: outputs must already read zero this cycle
               step(0, o, f3, f7, eq, lt, ltu, 0, '0, "async_reset_in_mem");
               reset_seq(1);
               return;
            end
            step(1, o, f3, f7, eq, lt, ltu, 0, ref_mem(o, 0), "mem_stall");
         end
         step(1, o, f3, f7, eq, lt, ltu, 1, ref_mem(o, 1), "mem_ready");
      end
   endtask

   initial begin
      logic [6:0] kinds [10];
      logic [6:0] o;
      int         ms, ra;
      kinds = '{OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, 7'h00};

      reset_seq(3);
      instr(OP,     3'b000, 0, 0, 0, 0, 0, 0, -1);   // ADD
      instr(OP,     3'b000, 1, 0, 0, 0, 1, 0, -1);   // SUB
      instr(BRANCH, 3'b001, 0, 0, 0, 0, 0, 0, -1);   // BNE, not equal -> taken
      instr(BRANCH, 3'b001, 0, 1, 0, 0, 0, 0, -1);   // BNE, equal -> not taken
      instr(BRANCH, 3'b010, 0, 1, 1, 1, 0, 0, -1);   // invalid FUNC3 -> not taken
      instr(LOAD,   3'b010, 0, 0, 0, 0, 0, 3, -1);   // LW, 3 stall cycles
      instr(STORE,  3'b010, 0, 0, 0, 0, 2, 1, -1);   // SW
      instr(OPIMM,  3'b101, 1, 0, 0, 0, 0, 0, -1);   // SRAI
      instr(OPIMM,  3'b000, 1, 0, 0, 0, 0, 0, -1);   // ADDI ignores FUNC7_5
      instr(LUI,    3'b000, 0, 0, 0, 0, 0, 0, -1);
      instr(7'h7f,  3'b000, 0, 0, 0, 0, 0, 0, -1);   // unknown opcode
      instr(LOAD,   3'b010, 0, 0, 0, 0, 1, 4,  2);   // reset during MEM stall

      for (int n = 0; n < 250; n++) begin
         o = kinds[$urandom_range(0, 9)];
         if (o == 7'h00) begin
            do o = 7'($urandom); while (is_known(o));
         end
         ms = $urandom_range(0, 3);
         ra = (ms > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, ms - 1) : -1;
         instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), ms, ra);
      end

      repeat (3) @(negedge CLK);
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
